axi4_lite_master_arbiter: RTL and testbench
===========================================

Name: axi4_lite_master_arbiter

Overview:
- Round-robin arbiter that shares one AXI4-Lite master's control port between NUM_REQ local requesters.
- Sits between requester blocks (DMA descriptors, CSR sequencers, debug bridge) and the master's ctrl_* interface.
- Owns the master exclusively per transaction: grant, one-cycle issue pulse, wait for done, route result back.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 32, data width; must match the master
ADDRESS_WIDTH, 32, address width; must match the master
TIMEOUT_CYCLES, 256, watchdog limit in cycles (used only with ARB_TIMEOUT_EN)

Ports:
ACLK  in  1  clock
ARESETn  in  1  asynchronous active-low reset
req_write  in  NUM_REQ  per-requester write request; hold until req_done
req_read  in  NUM_REQ  per-requester read request; hold until req_done
req_addr  in  NUM_REQ*ADDRESS_WIDTH  packed addresses, slice i = requester i
req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data
req_wstrb  in  NUM_REQ*DATA_WIDTH/8  packed write strobes
req_done  out  NUM_REQ  one-hot one-cycle completion pulse
req_rdata  out  DATA_WIDTH  read data, valid when req_done high
req_resp  out  2  AXI response, valid when req_done high
req_busy  out  1  high while any transaction is owned (state != IDLE)
m_addr / m_wdata / m_wstrb  out  ADDRESS_WIDTH / DATA_WIDTH / DATA_WIDTH/8  to master ctrl_addr/ctrl_wdata/ctrl_wstrb
m_write_req / m_read_req  out  1 / 1  one-cycle issue pulses to master
m_rdata  in  DATA_WIDTH  from master ctrl_rdata
m_resp  in  2  from master ctrl_resp
m_write_done / m_read_done  in  1 / 1  from master done pulses

Behaviour:
- Reset: all outputs 0; m_wstrb all-ones; rr pointer 0; state IDLE.
- FSM states: IDLE, ISSUE, WAIT, RESP (plus DRAIN when the option is enabled).
- IDLE: request vector = req_write|req_read. Grant the first set bit at or after the rr pointer (modulo NUM_REQ).
  - Register grant index, op (write if req_write[g], else read), and the address/wdata/wstrb slices into m_*.
  - Go to ISSUE. No request: stay in IDLE.
- ISSUE: exactly one cycle of m_write_req or m_read_req; then WAIT.
- m_addr/m_wdata/m_wstrb are held stable from ISSUE until leaving WAIT. The master samples them late, so they must not change.
- WAIT: wait for the done pulse matching op. The done of the other type is ignored.
  - On match: capture m_rdata (read only; otherwise keep the previous value) and m_resp; go to RESP.
- RESP: req_done[g]=1 for one cycle, req_rdata/req_resp driven from captured values; rr pointer <= g+1 (wraps to 0); go to IDLE.
- Requester contract: deassert the request at the edge where it samples req_done. Since IDLE follows RESP, no double issue occurs.
- Requester with both req_write and req_read set: write is served first. Read stays pending and competes in the next arbitration (fair to others).
- Latency: request seen in IDLE at edge t -> m_*_req high in cycle t+1 -> req_done one cycle after the master done pulse. Minimum 3 arbiter cycles plus master latency.
- Request changes outside IDLE are ignored. A requester dropping its request mid-transaction still receives req_done.
- Reset mid-transaction: immediate return to the reset state. Any in-flight master done is ignored because state is IDLE.

Optional Feature:
- ARB_TIMEOUT_EN defined: a counter runs in WAIT.
  - On reaching TIMEOUT_CYCLES with no matching done: go to RESP with req_resp=2'b11 (DECERR) and req_rdata=0.
  - Then go to DRAIN instead of IDLE. DRAIN blocks new grants (req_busy=1) until the late matching done arrives, then goes to IDLE.
- ARB_TIMEOUT_EN undefined: no counter, no DRAIN; WAIT waits indefinitely.

Test Plan:
- Single write: req_write[1]=1, addr 0x10, wdata 0xDEADBEEF, wstrb 0xF, master done after 5 cycles with resp 0 -> one m_write_req pulse; m_addr=0x10 held through WAIT; req_done=4'b0010 one cycle; req_resp=0.
- Single read: req_read[2]=1, addr 0x20; master returns 0x12345678, resp 0 -> req_done[2] pulse; req_rdata=0x12345678.
- Round-robin: all four requesters write simultaneously and re-request immediately -> grant order 0,1,2,3,0; no requester starved; one issue pulse per grant.
- Write+read same requester: req_write[0]=req_read[0]=1, req_write[3]=1 -> order write0, write3, read0.
- Slave error plus reset: master resp 2'b10 -> req_resp=2'b10. Assert ARESETn low during WAIT -> all outputs 0; a later master done produces no req_done.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16: master silent -> req_done with resp 2'b11 after 16 WAIT cycles; new requests blocked until the late m_write_done arrives.

Source files
------------

// File: rtl/axi4_lite_master_arbiter.sv
// Round-robin arbiter that shares one AXI4-Lite master control port among NUM_REQ requesters.
// Optional watchdog: define ARB_TIMEOUT_EN to enable the WAIT timeout (DECERR response + DRAIN state).
module axi4_lite_master_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int DATA_WIDTH     = 32,
   parameter int ADDRESS_WIDTH  = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                              ACLK,
   input  logic                              ARESETn,
   input  logic [NUM_REQ-1:0]                req_write,
   input  logic [NUM_REQ-1:0]                req_read,
   input  logic [NUM_REQ*ADDRESS_WIDTH-1:0]  req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_wdata,
   input  logic [NUM_REQ*DATA_WIDTH/8-1:0]   req_wstrb,
   output logic [NUM_REQ-1:0]                req_done,
   output logic [DATA_WIDTH-1:0]             req_rdata,
   output logic [1:0]                        req_resp,
   output logic                              req_busy,
   output logic [ADDRESS_WIDTH-1:0]          m_addr,
   output logic [DATA_WIDTH-1:0]             m_wdata,
   output logic [DATA_WIDTH/8-1:0]           m_wstrb,
   output logic                              m_write_req,
   output logic                              m_read_req,
   input  logic [DATA_WIDTH-1:0]             m_rdata,
   input  logic [1:0]                        m_resp,
   input  logic                              m_write_done,
   input  logic                              m_read_done
);
   localparam int IDX_W  = $clog2(NUM_REQ);
   localparam int STRB_W = DATA_WIDTH / 8;

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, DRAIN} state_t;
   state_t state_reg, state_next;

   logic [IDX_W-1:0]      rr_ptr_reg, grant_reg, grant_next;
   logic                  op_write_reg, grant_found, done_match;
   logic [DATA_WIDTH-1:0] rdata_reg;
   logic [1:0]            resp_reg;
   logic [NUM_REQ-1:0]    req_any;
   int                    scan_idx;

   assign req_any    = req_write | req_read;
   assign done_match = op_write_reg ? m_write_done : m_read_done;

   // First requester at or after the round-robin pointer, wrapping modulo NUM_REQ.
   always_comb begin
      grant_found = 1'b0;
      grant_next  = '0;
      scan_idx    = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         scan_idx = int'(rr_ptr_reg) + i;
         if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
         if (!grant_found && req_any[IDX_W'(scan_idx)]) begin
            grant_found = 1'b1;
            grant_next  = IDX_W'(scan_idx);
         end
      end
   end

`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] wait_cnt_reg;
   logic             timed_out_reg, timeout_hit;

   assign timeout_hit = (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn)                wait_cnt_reg <= '0;
      else if (state_reg == WAIT)  wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
      else                         wait_cnt_reg <= '0;
   end
`endif

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) state_reg <= IDLE;
      else          state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:  if (grant_found) state_next = ISSUE;
         ISSUE: state_next = WAIT;
         WAIT: begin
            if (done_match) state_next = RESP;
`ifdef ARB_TIMEOUT_EN
            else if (timeout_hit) state_next = RESP;
`endif
         end
`ifdef ARB_TIMEOUT_EN
         RESP:  state_next = timed_out_reg ? DRAIN : IDLE;
         DRAIN: if (done_match) state_next = IDLE;
`else
         RESP:  state_next = IDLE;
`endif
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      req_done    = '0;
      m_write_req = 1'b0;
      m_read_req  = 1'b0;
      case (state_reg)
         ISSUE: begin
            m_write_req = op_write_reg;
            m_read_req  = !op_write_reg;
         end
         RESP:    req_done[grant_reg] = 1'b1;
         default: ;
      endcase
   end

   assign req_busy  = (state_reg != IDLE);
   assign req_rdata = rdata_reg;
   assign req_resp  = resp_reg;

   // m_* only load on a grant, so they stay stable through ISSUE/WAIT (and DRAIN).
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         rr_ptr_reg    <= '0;
         grant_reg     <= '0;
         op_write_reg  <= 1'b0;
         m_addr        <= '0;
         m_wdata       <= '0;
         m_wstrb       <= '1;
         rdata_reg     <= '0;
         resp_reg      <= '0;
`ifdef ARB_TIMEOUT_EN
         timed_out_reg <= 1'b0;
`endif
      end else begin
         case (state_reg)
            IDLE: begin
`ifdef ARB_TIMEOUT_EN
               timed_out_reg <= 1'b0;
`endif
               if (grant_found) begin
                  grant_reg    <= grant_next;
                  op_write_reg <= req_write[grant_next];
                  m_addr       <= req_addr[int'(grant_next)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                  m_wdata      <= req_wdata[int'(grant_next)*DATA_WIDTH +: DATA_WIDTH];
                  m_wstrb      <= req_wstrb[int'(grant_next)*STRB_W +: STRB_W];
               end
            end
            WAIT: begin
               if (done_match) begin
                  if (!op_write_reg) rdata_reg <= m_rdata;
                  resp_reg <= m_resp;
               end
`ifdef ARB_TIMEOUT_EN
               else if (timeout_hit) begin
                  rdata_reg     <= '0;
                  resp_reg      <= 2'b11;
                  timed_out_reg <= 1'b1;
               end
`endif
            end
            RESP: rr_ptr_reg <= (grant_reg == IDX_W'(NUM_REQ - 1)) ? '0 : grant_reg + IDX_W'(1);
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_axi4_lite_master_arbiter.sv
// Self-checking bench for axi4_lite_master_arbiter: vector table, hand sequences, issue/completion scoreboard.
// Build with ARB_TIMEOUT_EN defined to also exercise the watchdog/DRAIN path.
module tb_axi4_lite_master_arbiter;
   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;
`ifdef ARB_TIMEOUT_EN
   localparam int TMO = 16;
`else
   localparam int TMO = 256;
`endif

   logic          ACLK = 1'b0;
   logic          ARESETn;
   logic [N-1:0]  req_write, req_read, req_done;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata;
   logic [N*SW-1:0] req_wstrb;
   logic [DW-1:0] req_rdata, m_wdata, m_rdata;
   logic [1:0]    req_resp, m_resp;
   logic          req_busy, m_write_req, m_read_req, m_write_done, m_read_done;
   logic [AW-1:0] m_addr;
   logic [SW-1:0] m_wstrb;

   axi4_lite_master_arbiter #(
      .NUM_REQ(N), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .req_write(req_write), .req_read(req_read), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .req_done(req_done), .req_rdata(req_rdata), .req_resp(req_resp), .req_busy(req_busy),
      .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
      .m_write_req(m_write_req), .m_read_req(m_read_req),
      .m_rdata(m_rdata), .m_resp(m_resp),
      .m_write_done(m_write_done), .m_read_done(m_read_done)
   );

   always #5 ACLK = ~ACLK;

   typedef struct {
      bit          wr;
      int          idx;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] mrdata;
      logic [1:0]  mresp;
      int          lat;
      bit          glitch;
      bit          nohold;
      bit          tmo;
      logic [31:0] exp_rdata;
      logic [1:0]  exp_resp;
      longint      issue_cyc;
   } txn_t;

   txn_t   iss_q[$];
   txn_t   cmp_q[$];
   int     checks = 0;
   int     errors = 0;
   longint cyc = 0;
   longint done_cyc = 0;
   longint iss_cyc = 0;
   logic [31:0] last_rdata = '0;
   int     rereq[N];

   always @(posedge ACLK) cyc <= cyc + 1;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic txn_t mk(bit wr, int idx, logic [31:0] addr, logic [31:0] wdata,
                               logic [3:0] wstrb, logic [31:0] mrdata, logic [1:0] mresp,
                               int lat, bit glitch);
      txn_t t;
      t.wr = wr; t.idx = idx; t.addr = addr; t.wdata = wdata; t.wstrb = wstrb;
      t.mrdata = mrdata; t.mresp = mresp; t.lat = lat; t.glitch = glitch;
      t.nohold = 1'b0; t.tmo = 1'b0; t.exp_rdata = '0; t.exp_resp = mresp; t.issue_cyc = -1;
      return t;
   endfunction

   // Expected completion data: a write leaves the last read data in place; a timeout clears it.
   task automatic push(txn_t t);
      if (t.tmo) begin
         t.exp_rdata = '0; t.exp_resp = 2'b11; last_rdata = '0;
      end else if (t.wr) begin
         t.exp_rdata = last_rdata;
      end else begin
         t.exp_rdata = t.mrdata; last_rdata = t.mrdata;
      end
      iss_q.push_back(t);
      cmp_q.push_back(t);
   endtask

   task automatic set_req(txn_t t);
      req_addr[t.idx*AW +: AW]  = t.addr;
      req_wdata[t.idx*DW +: DW] = t.wdata;
      req_wstrb[t.idx*SW +: SW] = t.wstrb;
      if (t.wr) req_write[t.idx] = 1'b1;
      else      req_read[t.idx]  = 1'b1;
   endtask

   // Completion checker plus requester agent (drops the served request on req_done).
   task automatic service();
      txn_t t;
      logic [N-1:0] ev;
      if (ARESETn !== 1'b1) return;
      if (req_done != '0) begin
         if (cmp_q.size() == 0) begin
            chk("spurious_done", req_done, '0);
         end else begin
            t = cmp_q.pop_front();
            ev = '0;
            ev[t.idx] = 1'b1;
            $display("txn: requester %0d %s resp=%0h rdata=%08h", t.idx, t.wr ? "write" : "read",
                     req_resp, req_rdata);
            chk("done_vec", req_done, ev);
            chk("done_rdata", req_rdata, t.exp_rdata);
            chk("done_resp", req_resp, t.exp_resp);
            chk("done_busy", req_busy, 1'b1);
            if (t.tmo) chk("tmo_lat", cyc, iss_cyc + TMO + 1);
            else       chk("done_lat", cyc, done_cyc + 1);
         end
         for (int i = 0; i < N; i++) begin
            if (req_done[i]) begin
               if (req_write[i]) begin
                  if (rereq[i] > 0) rereq[i]--;
                  else req_write[i] = 1'b0;
               end else begin
                  req_read[i] = 1'b0;
               end
            end
         end
      end
   endtask

   task automatic tick();
      @(negedge ACLK);
      service();
   endtask

   task automatic run_until_empty(int budget);
      int n;
      n = 0;
      while (cmp_q.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      if (cmp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: %0d transactions outstanding, expected 0", cmp_q.size());
         cmp_q.delete();
         req_write = '0;
         req_read  = '0;
      end
   endtask

   task automatic do_reset();
      ARESETn   = 1'b0;
      req_write = '0;
      req_read  = '0;
      cmp_q.delete();
      tick();
      tick();
      chk("rst_busy", req_busy, 1'b0);
      chk("rst_done", req_done, '0);
      chk("rst_wreq", m_write_req, 1'b0);
      chk("rst_rreq", m_read_req, 1'b0);
      chk("rst_addr", m_addr, '0);
      chk("rst_wdata", m_wdata, '0);
      chk("rst_wstrb", m_wstrb, 4'hF);
      chk("rst_rdata", req_rdata, '0);
      chk("rst_resp", req_resp, '0);
      last_rdata = '0;
      ARESETn = 1'b1;
      tick();
   endtask

   // Master model: checks each issue pulse against the scoreboard, answers after t.lat cycles.
   initial begin : master
      txn_t cur;
      int   cnt;
      int   iss_rd;
      bit   pend;
      m_write_done = 1'b0; m_read_done = 1'b0; m_rdata = '0; m_resp = '0;
      cnt = 0; iss_rd = 0; pend = 1'b0;
      forever begin
         @(negedge ACLK);
         m_write_done = 1'b0;
         m_read_done  = 1'b0;
         if (pend) begin
            cnt--;
            if (cnt == 0) begin
               pend = 1'b0;
               done_cyc = cyc;
               m_rdata = cur.wr ? 32'hBAD0_BAD0 : cur.mrdata;
               m_resp  = cur.mresp;
               if (cur.wr) m_write_done = 1'b1;
               else        m_read_done  = 1'b1;
               if (!cur.nohold) begin
                  chk("hold_addr", m_addr, cur.addr);
                  chk("hold_wdata", m_wdata, cur.wdata);
                  chk("hold_wstrb", m_wstrb, cur.wstrb);
               end
            end else if (cur.glitch && cnt == cur.lat - 1) begin
               m_rdata = 32'hEEEE_EEEE;
               m_resp  = 2'b11;
               if (cur.wr) m_read_done  = 1'b1;
               else        m_write_done = 1'b1;
            end
         end
         if (m_write_req || m_read_req) begin
            chk("issue_onehot", m_write_req & m_read_req, 1'b0);
            chk("issue_while_busy", pend, 1'b0);
            if (iss_rd >= iss_q.size()) begin
               chk("unexpected_issue", {m_write_req, m_read_req}, 2'b00);
            end else begin
               cur = iss_q[iss_rd];
               iss_rd++;
               iss_cyc = cyc;
               chk("issue_op", m_write_req, cur.wr);
               chk("issue_addr", m_addr, cur.addr);
               chk("issue_wdata", m_wdata, cur.wdata);
               chk("issue_wstrb", m_wstrb, cur.wstrb);
               if (cur.issue_cyc >= 0) chk("issue_lat", cyc, cur.issue_cyc);
               pend = 1'b1;
               cnt  = cur.lat;
            end
         end
      end
   end

   initial begin : main
      txn_t vecs[5];
      txn_t t;
      ARESETn = 1'b0;
      req_write = '0; req_read = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
      for (int i = 0; i < N; i++) rereq[i] = 0;

      vecs[0] = mk(1, 1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 2'b00, 5, 0);
      vecs[1] = mk(0, 2, 32'h20, 32'h0, 4'hF, 32'h12345678, 2'b00, 3, 0);
      vecs[2] = mk(1, 3, 32'h3C, 32'h0000A5A5, 4'h3, 32'h0, 2'b10, 1, 0);
      vecs[3] = mk(0, 0, 32'h44, 32'h0, 4'hF, 32'hCAFEF00D, 2'b01, 4, 1);
      vecs[4] = mk(1, 2, 32'hFFFFFFFC, 32'hFFFFFFFF, 4'h1, 32'h0, 2'b00, 6, 1);

      do_reset();

      // Isolated transactions: issue latency, hold, result routing, wrong-type done ignored.
      for (int v = 0; v < 5; v++) begin
         chk("idle_busy", req_busy, 1'b0);
         t = vecs[v];
         t.issue_cyc = cyc + 1;
         push(t);
         set_req(t);
         run_until_empty(100);
         tick();
      end

      // Round robin: all four write, requester 0 re-requests once -> 0,1,2,3,0.
      do_reset();
      rereq[0] = 1;
      for (int i = 0; i < N; i++) begin
         t = mk(1, i, 32'h40 + 32'(i*4), 32'hA0 + 32'(i), 4'hF, 32'h0, 2'b00, 2, 0);
         push(t);
      end
      push(mk(1, 0, 32'h40, 32'hA0, 4'hF, 32'h0, 2'b00, 2, 0));
      for (int i = 0; i < N; i++) set_req(iss_q[iss_q.size() - 5 + i]);
      run_until_empty(200);
      tick();
      chk("rr_idle", req_busy, 1'b0);

      // Same requester writes and reads: write0, write3, read0.
      do_reset();
      t = mk(1, 0, 32'h100, 32'h11111111, 4'hF, 32'h0, 2'b00, 2, 0);
      push(t); set_req(t);
      t = mk(1, 3, 32'h300, 32'h33333333, 4'hF, 32'h0, 2'b00, 2, 0);
      push(t); set_req(t);
      t = mk(0, 0, 32'h100, 32'h11111111, 4'hF, 32'h600DF00D, 2'b00, 2, 0);
      push(t); set_req(t);
      run_until_empty(200);
      tick();

      // Reset during WAIT: outputs clear at once, the late master done is ignored.
      t = mk(1, 1, 32'h80, 32'h55AA55AA, 4'hC, 32'h0, 2'b10, 10, 0);
      t.nohold = 1'b1;
      push(t); set_req(t);
      repeat (4) tick();
      chk("wait_busy", req_busy, 1'b1);
      ARESETn = 1'b0;
      #1;
      chk("mid_rst_busy", req_busy, 1'b0);
      chk("mid_rst_addr", m_addr, '0);
      chk("mid_rst_wstrb", m_wstrb, 4'hF);
      chk("mid_rst_done", req_done, '0);
      req_write = '0; req_read = '0;
      cmp_q.delete();
      last_rdata = '0;
      tick();
      ARESETn = 1'b1;
      repeat (20) tick();
      chk("post_rst_idle", req_busy, 1'b0);

`ifdef ARB_TIMEOUT_EN
      // Silent master: DECERR after TMO WAIT cycles, then DRAIN blocks requester 2 until the late done.
      t = mk(1, 1, 32'h200, 32'h1, 4'hF, 32'h0, 2'b00, 40, 0);
      t.tmo = 1'b1;
      push(t); set_req(t);
      tick(); tick();
      t = mk(1, 2, 32'h204, 32'h2, 4'hF, 32'h0, 2'b00, 2, 0);
      push(t); set_req(t);
      run_until_empty(300);
      tick();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1, "global timeout");
   end
endmodule
